// File: rtl/obj_row_scanner_pkg.sv
// Shared constants, object-entry layout and FSM encoding for the object row scanner.
package obj_row_scanner_pkg;

    localparam int NUM_COLS = 19;
    localparam int NUM_ROWS = 15;
    localparam int ACTIVE_H = 608;
    localparam int ACTIVE_V = 480;

    localparam int OBJ_W        = 13;
    localparam int OBJ_ON_BIT   = 12;
    localparam int OBJ_TILE_LSB = 9;
    localparam int OBJ_TILE_W   = 3;
    localparam int OBJ_X_LSB    = 4;
    localparam int OBJ_X_W      = 5;
    localparam int OBJ_Y_LSB    = 0;
    localparam int OBJ_Y_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2
    } scanState_t;

    typedef struct packed {
        logic                  isOn;
        logic [OBJ_TILE_W-1:0] tile;
        logic [OBJ_X_W-1:0]    x;
        logic [OBJ_Y_W-1:0]    y;
    } objEntry_t;

    function automatic objEntry_t decodeObj(input logic [OBJ_W-1:0] w);
        objEntry_t e;
        e.isOn = w[OBJ_ON_BIT];
        e.tile = w[OBJ_TILE_LSB +: OBJ_TILE_W];
        e.x    = w[OBJ_X_LSB +: OBJ_X_W];
        e.y    = w[OBJ_Y_LSB +: OBJ_Y_W];
        return e;
    endfunction

endpackage

// File: rtl/obj_row_scanner_ram.sv
// Object RAM: resettable register file, one write port, one combinational read port.
module obj_ram
    import obj_row_scanner_pkg::*;
#(
    parameter int NUM_OBJ = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       iWrAddr,
    input  logic [OBJ_W-1:0] iWrData,
    input  logic             iWe,
    input  logic [3:0]       iRdAddr,
    output logic [OBJ_W-1:0] oRdData
);

    logic [OBJ_W-1:0] rdArr [NUM_OBJ];

    generate
        for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : gEntry
            logic [OBJ_W-1:0] entryReg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    entryReg <= '0;
                end else if (iWe && iWrAddr == 4'(gi)) begin
                    entryReg <= iWrData;
                end
            end

            assign rdArr[gi] = entryReg;
        end
    endgenerate

    // Read sees the pre-write value in the cycle of a write.
    assign oRdData = rdArr[iRdAddr];

endmodule

// File: rtl/obj_row_scanner.sv
// Per-line object scanner: fills a 19-column tile buffer during blanking,
// then looks up the covering object for each pixel with a 2-cycle pipeline.
module obj_row_scanner
    import obj_row_scanner_pkg::*;
#(
    parameter int NUM_OBJ    = 16,
    parameter int X_OFFSET   = 16,
    parameter int TILE_SHIFT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       iObjRam_addr,
    input  logic [OBJ_W-1:0] iObjRam_data,
    input  logic             iObjRam_we,
    input  logic [9:0]       iHCnt,
    input  logic [9:0]       iVCnt,
    input  logic             iLineStart,
    output logic             oTile_valid,
    output logic [2:0]       oTile_no,
    output logic [4:0]       oTile_px,
    output logic [4:0]       oTile_py,
    output logic             oScan_busy,
    output logic             oOverrun
);

    localparam logic [10:0] H_LO = 11'(X_OFFSET);
    localparam logic [10:0] H_HI = 11'(X_OFFSET + ACTIVE_H);

    scanState_t       stateReg;
    logic [4:0]       cntReg;
    logic [3:0]       rowReg;
    logic             busyReg;
    logic             overrunReg;

    logic [OBJ_W-1:0] ramRdData;
    objEntry_t        rdObj;
    logic             trigger;
    logic             scanHit;
    logic             scanWr;
    logic             clearWr;

    logic [NUM_COLS-1:0] bufValid;
    logic [2:0]          bufTile [NUM_COLS];

    obj_ram #(.NUM_OBJ(NUM_OBJ)) uObjRam (
        .clk     (clk),
        .reset   (reset),
        .iWrAddr (iObjRam_addr),
        .iWrData (iObjRam_data),
        .iWe     (iObjRam_we),
        .iRdAddr (cntReg[3:0]),
        .oRdData (ramRdData)
    );

    assign trigger = iLineStart && (iVCnt < 10'(ACTIVE_V)) && (iVCnt[4:0] == 5'd0);
    assign rdObj   = decodeObj(ramRdData);
    assign scanHit = (stateReg == SCAN) && rdObj.isOn && (rdObj.y == rowReg)
                     && (rdObj.x < 5'(NUM_COLS));
    // An already-valid column keeps its tile, so the lowest RAM address wins.
    assign scanWr  = scanHit && !bufValid[rdObj.x];
    assign clearWr = (stateReg == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            rowReg     <= '0;
            busyReg    <= 1'b0;
            overrunReg <= 1'b0;
        end else begin
            overrunReg <= trigger && busyReg;
            case (stateReg)
                IDLE: begin
                    if (trigger) begin
                        stateReg <= CLEAR;
                        cntReg   <= '0;
                        rowReg   <= 4'(iVCnt >> TILE_SHIFT);
                        busyReg  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cntReg == 5'(NUM_COLS - 1)) begin
                        stateReg <= SCAN;
                        cntReg   <= '0;
                    end else begin
                        cntReg <= cntReg + 5'd1;
                    end
                end
                SCAN: begin
                    if (cntReg == 5'(NUM_OBJ - 1)) begin
                        stateReg <= IDLE;
                        cntReg   <= '0;
                        busyReg  <= 1'b0;
                    end else begin
                        cntReg <= cntReg + 5'd1;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    cntReg   <= '0;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : gCol
            logic       validReg;
            logic [2:0] tileReg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    validReg <= 1'b0;
                    tileReg  <= '0;
                end else if (clearWr && cntReg == 5'(gi)) begin
                    validReg <= 1'b0;
                end else if (scanWr && rdObj.x == 5'(gi)) begin
                    validReg <= 1'b1;
                    tileReg  <= rdObj.tile;
                end
            end

            assign bufValid[gi] = validReg;
            assign bufTile[gi]  = tileReg;
        end
    endgenerate

    logic [10:0] hExt;
    logic [9:0]  hRel;
    logic        inRange;
    logic        s1InRange;
    logic [4:0]  s1Col;
    logic [4:0]  s1Px;
    logic [4:0]  s1Py;
    logic        s2Hit;

    assign hExt    = {1'b0, iHCnt};
    assign hRel    = iHCnt - 10'(X_OFFSET);
    assign inRange = (hExt >= H_LO) && (hExt < H_HI) && (iVCnt < 10'(ACTIVE_V));
    assign s2Hit   = s1InRange && (s1Col < 5'(NUM_COLS)) && bufValid[s1Col];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1InRange   <= 1'b0;
            s1Col       <= '0;
            s1Px        <= '0;
            s1Py        <= '0;
            oTile_valid <= 1'b0;
            oTile_no    <= '0;
            oTile_px    <= '0;
            oTile_py    <= '0;
        end else begin
            s1InRange   <= inRange;
            s1Col       <= 5'(hRel >> TILE_SHIFT);
            s1Px        <= hRel[4:0];
            s1Py        <= iVCnt[4:0];
            oTile_valid <= s2Hit;
            oTile_no    <= s2Hit ? bufTile[s1Col] : 3'd0;
            oTile_px    <= s1Px;
            oTile_py    <= s1Py;
        end
    end

    assign oScan_busy = busyReg;
    assign oOverrun   = overrunReg;

endmodule

// File: tb/tb_obj_row_scanner.sv
// Directed self-checking bench for obj_row_scanner.
module tb_obj_row_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  iObjRam_addr;
    logic [12:0] iObjRam_data;
    logic        iObjRam_we;
    logic [9:0]  iHCnt;
    logic [9:0]  iVCnt;
    logic        iLineStart;
    logic        oTile_valid;
    logic [2:0]  oTile_no;
    logic [4:0]  oTile_px;
    logic [4:0]  oTile_py;
    logic        oScan_busy;
    logic        oOverrun;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic [2:0] no;
        logic [4:0] px;
        logic [4:0] py;
    } probe_t;

    always #5 clk = ~clk;

    obj_row_scanner dut (
        .clk          (clk),
        .reset        (reset),
        .iObjRam_addr (iObjRam_addr),
        .iObjRam_data (iObjRam_data),
        .iObjRam_we   (iObjRam_we),
        .iHCnt        (iHCnt),
        .iVCnt        (iVCnt),
        .iLineStart   (iLineStart),
        .oTile_valid  (oTile_valid),
        .oTile_no     (oTile_no),
        .oTile_px     (oTile_px),
        .oTile_py     (oTile_py),
        .oScan_busy   (oScan_busy),
        .oOverrun     (oOverrun)
    );

    function automatic probe_t mk(input int h, input int v, input bit val,
                                  input int no, input int px, input int py);
        probe_t p;
        p.h = 10'(h); p.v = 10'(v); p.valid = val;
        p.no = 3'(no); p.px = 5'(px); p.py = 5'(py);
        return p;
    endfunction

    // Stimulus helpers: all start and end just after a falling edge.
    task automatic writeObj(input logic [3:0] a, input logic [12:0] d);
        iObjRam_addr = a; iObjRam_data = d; iObjRam_we = 1'b1;
        @(negedge clk);
        iObjRam_we = 1'b0;
        $display("write addr=%0d data=0x%04h", a, d);
    endtask

    task automatic clearRam();
        for (int i = 0; i < 16; i++) writeObj(4'(i), 13'd0);
    endtask

    task automatic runScan(input logic [9:0] v, output int cycles);
        iLineStart = 1'b1; iVCnt = v;
        @(negedge clk);
        iLineStart = 1'b0;
        cycles = 0;
        while (oScan_busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        $display("scan v=%0d busy_cycles=%0d", v, cycles);
    endtask

    task automatic lookup(input logic [9:0] h, input logic [9:0] v);
        iHCnt = h; iVCnt = v;
        repeat (2) @(negedge clk);
        $display("lookup h=%0d v=%0d -> valid=%0b no=%0d px=%0d py=%0d",
                 h, v, oTile_valid, oTile_no, oTile_px, oTile_py);
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b1; iHCnt = 10'd116; iVCnt = 10'd64;
        repeat (3) @(negedge clk);
        nChecks++;
        if ({oScan_busy, oOverrun, oTile_valid, oTile_no, oTile_px, oTile_py} !== 16'd0) begin
            nFails++;
            $display("FAIL reset_outputs: got busy=%0b ovr=%0b valid=%0b no=%0d px=%0d py=%0d, want all 0",
                     oScan_busy, oOverrun, oTile_valid, oTile_no, oTile_px, oTile_py);
        end
        reset = 1'b0;
        lookup(10'd116, 10'd64);
        nChecks++;
        if ({oTile_valid, oTile_no, oTile_px, oTile_py} !== {1'b0, 3'd0, 5'd4, 5'd0}) begin
            nFails++;
            $display("FAIL reset_buffer_empty: got valid=%0b no=%0d px=%0d py=%0d, want 0/0/4/0",
                     oTile_valid, oTile_no, oTile_px, oTile_py);
        end
        runScan(10'd64, cyc);
        nChecks++;
        if (cyc != 35) begin
            nFails++;
            $display("FAIL reset_scan_len: got %0d busy cycles, want 35", cyc);
        end
        lookup(10'd116, 10'd64);
        nChecks++;
        if (oTile_valid !== 1'b0) begin
            nFails++;
            $display("FAIL reset_ram_empty: got valid=%0b, want 0", oTile_valid);
        end
    endtask

    task automatic test_single_object();
        int cyc;
        logic [9:0] hs [36];
        writeObj(4'd0, 13'h1032);
        runScan(10'd64, cyc);
        nChecks++;
        if (cyc != 35) begin
            nFails++;
            $display("FAIL single_scan_len: got %0d busy cycles, want 35", cyc);
        end
        // Stream 110..145 one pixel per clock; output lags input by two clocks.
        for (int i = 0; i <= 36; i++) begin
            if (i < 36) begin
                hs[i] = 10'(110 + i);
                iHCnt = hs[i]; iVCnt = 10'd64;
            end
            @(negedge clk);
            if (i >= 1) begin
                int h;
                logic expV;
                logic [4:0] expPx;
                h = int'(hs[i-1]);
                expV = (h >= 112 && h <= 143);
                expPx = 5'((h - 16) % 32);
                nChecks++;
                if ({oTile_valid, oTile_no, oTile_px, oTile_py} !== {expV, 3'd0, expPx, 5'd0}) begin
                    nFails++;
                    $display("FAIL single_stream h=%0d: got valid=%0b no=%0d px=%0d py=%0d, want valid=%0b no=0 px=%0d py=0",
                             h, oTile_valid, oTile_no, oTile_px, oTile_py, expV, expPx);
                end
            end
        end
    endtask

    task automatic test_priority();
        int cyc;
        probe_t tbl [4];
        writeObj(4'd0, 13'h1051);
        writeObj(4'd1, 13'h1251);
        writeObj(4'd2, 13'h1C61);
        runScan(10'd32, cyc);
        tbl = '{mk(183, 33, 1, 0, 7, 1), mk(239, 33, 1, 6, 31, 1),
                mk(112, 33, 0, 0, 0, 1), mk(208, 33, 1, 6, 0, 1)};
        foreach (tbl[i]) begin
            lookup(tbl[i].h, tbl[i].v);
            nChecks++;
            if ({oTile_valid, oTile_no, oTile_px, oTile_py} !== {tbl[i].valid, tbl[i].no, tbl[i].px, tbl[i].py}) begin
                nFails++;
                $display("FAIL priority[%0d] h=%0d v=%0d: got valid=%0b no=%0d px=%0d py=%0d, want valid=%0b no=%0d px=%0d py=%0d",
                         i, tbl[i].h, tbl[i].v, oTile_valid, oTile_no, oTile_px, oTile_py,
                         tbl[i].valid, tbl[i].no, tbl[i].px, tbl[i].py);
            end
        end
    endtask

    task automatic test_reject();
        int cyc;
        int hits;
        probe_t tbl [4];
        writeObj(4'd0, 13'h0051);
        writeObj(4'd1, 13'h1531);
        writeObj(4'd2, 13'h0000);
        writeObj(4'd3, 13'h1872);
        runScan(10'd32, cyc);
        hits = 0;
        for (int i = 0; i < 610; i++) begin
            if (i < 608) iHCnt = 10'(16 + i);
            iVCnt = 10'd33;
            @(negedge clk);
            if (oTile_valid !== 1'b0) hits++;
        end
        nChecks++;
        if (hits != 0) begin
            nFails++;
            $display("FAIL reject_row_sweep: got %0d covered pixels, want 0", hits);
        end
        tbl = '{mk(183, 33, 0, 0, 7, 1), mk(623, 33, 0, 0, 31, 1),
                mk(112, 33, 0, 0, 0, 1), mk(240, 33, 0, 0, 0, 1)};
        foreach (tbl[i]) begin
            lookup(tbl[i].h, tbl[i].v);
            nChecks++;
            if ({oTile_valid, oTile_no, oTile_px, oTile_py} !== {tbl[i].valid, tbl[i].no, tbl[i].px, tbl[i].py}) begin
                nFails++;
                $display("FAIL reject[%0d] h=%0d v=%0d: got valid=%0b no=%0d px=%0d py=%0d, want valid=%0b no=%0d px=%0d py=%0d",
                         i, tbl[i].h, tbl[i].v, oTile_valid, oTile_no, oTile_px, oTile_py,
                         tbl[i].valid, tbl[i].no, tbl[i].px, tbl[i].py);
            end
        end
    endtask

    task automatic test_overrun();
        int busyCnt, ovCnt, ovAt;
        probe_t tbl [2];
        writeObj(4'd0, 13'h1624);
        writeObj(4'd1, 13'h1223);
        busyCnt = 0; ovCnt = 0; ovAt = -1;
        iLineStart = 1'b1; iVCnt = 10'd128;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (oScan_busy === 1'b1) busyCnt++;
            if (oOverrun === 1'b1) begin
                ovCnt++;
                ovAt = k;
            end
            if (k == 1)  iLineStart = 1'b0;
            if (k == 10) begin iLineStart = 1'b1; iVCnt = 10'd96; end
            if (k == 11) iLineStart = 1'b0;
        end
        $display("overrun run: busy=%0d pulses=%0d last_pulse_cycle=%0d", busyCnt, ovCnt, ovAt);
        nChecks++;
        if (ovCnt != 1) begin
            nFails++;
            $display("FAIL overrun_pulse_count: got %0d, want 1", ovCnt);
        end
        nChecks++;
        if (ovAt != 11) begin
            nFails++;
            $display("FAIL overrun_pulse_cycle: got %0d, want 11", ovAt);
        end
        nChecks++;
        if (busyCnt != 35) begin
            nFails++;
            $display("FAIL overrun_busy_len: got %0d, want 35", busyCnt);
        end
        tbl = '{mk(85, 128, 1, 3, 5, 0), mk(85, 96, 1, 3, 5, 0)};
        foreach (tbl[i]) begin
            lookup(tbl[i].h, tbl[i].v);
            nChecks++;
            if ({oTile_valid, oTile_no, oTile_px, oTile_py} !== {tbl[i].valid, tbl[i].no, tbl[i].px, tbl[i].py}) begin
                nFails++;
                $display("FAIL overrun_row[%0d] h=%0d v=%0d: got valid=%0b no=%0d px=%0d py=%0d, want valid=%0b no=%0d px=%0d py=%0d",
                         i, tbl[i].h, tbl[i].v, oTile_valid, oTile_no, oTile_px, oTile_py,
                         tbl[i].valid, tbl[i].no, tbl[i].px, tbl[i].py);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc, hits;
        clearRam();
        writeObj(4'd0, 13'h1032);
        runScan(10'd64, cyc);
        iHCnt = 10'd116; iVCnt = 10'd64; iLineStart = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) iLineStart = 1'b0;
        end
        nChecks++;
        if ({oScan_busy, oTile_valid} !== 2'b11) begin
            nFails++;
            $display("FAIL resetmid_before: got busy=%0b valid=%0b, want 1/1", oScan_busy, oTile_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({oScan_busy, oOverrun, oTile_valid, oTile_no, oTile_px, oTile_py} !== 16'd0) begin
            nFails++;
            $display("FAIL resetmid_outputs: got busy=%0b ovr=%0b valid=%0b no=%0d px=%0d py=%0d, want all 0",
                     oScan_busy, oOverrun, oTile_valid, oTile_no, oTile_px, oTile_py);
        end
        reset = 1'b0;
        @(negedge clk);
        nChecks++;
        if (oScan_busy !== 1'b0) begin
            nFails++;
            $display("FAIL resetmid_idle: got busy=%0b, want 0", oScan_busy);
        end
        runScan(10'd64, cyc);
        nChecks++;
        if (cyc != 35) begin
            nFails++;
            $display("FAIL resetmid_scan_len: got %0d busy cycles, want 35", cyc);
        end
        hits = 0;
        for (int c = 0; c < 19; c++) begin
            lookup(10'(16 + 32 * c + 4), 10'd64);
            if (oTile_valid !== 1'b0) hits++;
        end
        nChecks++;
        if (hits != 0) begin
            nFails++;
            $display("FAIL resetmid_fresh: got %0d valid columns, want 0", hits);
        end
    endtask

    task automatic test_boundary();
        int cyc;
        probe_t tbl [8];
        writeObj(4'd0, 13'h1400);
        writeObj(4'd1, 13'h1F20);
        runScan(10'd0, cyc);
        tbl = '{mk(15, 0, 0, 0, 31, 0),   mk(16, 0, 1, 2, 0, 0),
                mk(623, 0, 1, 7, 31, 0),  mk(624, 0, 0, 0, 0, 0),
                mk(16, 480, 0, 0, 0, 0),  mk(16, 479, 1, 2, 0, 31),
                mk(47, 448, 1, 2, 31, 0), mk(591, 0, 0, 0, 31, 0)};
        foreach (tbl[i]) begin
            lookup(tbl[i].h, tbl[i].v);
            nChecks++;
            if ({oTile_valid, oTile_no, oTile_px, oTile_py} !== {tbl[i].valid, tbl[i].no, tbl[i].px, tbl[i].py}) begin
                nFails++;
                $display("FAIL boundary[%0d] h=%0d v=%0d: got valid=%0b no=%0d px=%0d py=%0d, want valid=%0b no=%0d px=%0d py=%0d",
                         i, tbl[i].h, tbl[i].v, oTile_valid, oTile_no, oTile_px, oTile_py,
                         tbl[i].valid, tbl[i].no, tbl[i].px, tbl[i].py);
            end
        end
    endtask

    task automatic test_trigger_qualify();
        int cyc;
        iLineStart = 1'b1; iVCnt = 10'd480;
        @(negedge clk);
        iLineStart = 1'b0;
        nChecks++;
        if (oScan_busy !== 1'b0) begin
            nFails++;
            $display("FAIL trig_v480: got busy=%0b, want 0", oScan_busy);
        end
        iLineStart = 1'b1; iVCnt = 10'd33;
        @(negedge clk);
        iLineStart = 1'b0;
        nChecks++;
        if (oScan_busy !== 1'b0) begin
            nFails++;
            $display("FAIL trig_v33: got busy=%0b, want 0", oScan_busy);
        end
        iLineStart = 1'b1; iVCnt = 10'd448;
        @(negedge clk);
        iLineStart = 1'b0;
        nChecks++;
        if (oScan_busy !== 1'b1) begin
            nFails++;
            $display("FAIL trig_v448: got busy=%0b, want 1", oScan_busy);
        end
        cyc = 0;
        while (oScan_busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        lookup(10'd16, 10'd0);
        nChecks++;
        if (oTile_valid !== 1'b0) begin
            nFails++;
            $display("FAIL trig_row14_cleared: got valid=%0b, want 0", oTile_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        iObjRam_addr = '0; iObjRam_data = '0; iObjRam_we = 1'b0;
        iHCnt = '0; iVCnt = '0; iLineStart = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_object();
        test_priority();
        test_reject();
        test_overrun();
        test_reset_mid_scan();
        test_boundary();
        test_trigger_qualify();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/obj_row_scanner.md
OBJ_ROW_SCANNER -- requirements
Module: obj_row_scanner

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 16: number of object RAM entries.
REQ-002 SHALL have parameter X_OFFSET, default 16: first active pixel column of the 19x15 tile grid.
REQ-003 SHALL have parameter TILE_SHIFT, default 5: log2 of the tile size (32 px).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port iObjRam_addr, input, 4: object RAM write address.
REQ-007 SHALL have port iObjRam_data, input, 13: object RAM write data; bit 12 ON, bits 11..9 tile, bits 8..4 X cell, bits 3..0 Y cell.
REQ-008 SHALL have port iObjRam_we, input, 1: object RAM write enable.
REQ-009 SHALL have port iHCnt, input, 10: current pixel column.
REQ-010 SHALL have port iVCnt, input, 10: line about to be displayed.
REQ-011 SHALL have port iLineStart, input, 1: one-cycle pulse at the start of horizontal blank.
REQ-012 SHALL have port oTile_valid, output, 1: an object covers the current pixel.
REQ-013 SHALL have port oTile_no, output, 3: tile number of the covering object.
REQ-014 SHALL have port oTile_px, output, 5: pixel X within the tile.
REQ-015 SHALL have port oTile_py, output, 5: pixel Y within the tile.
REQ-016 SHALL have port oScan_busy, output, 1: row scan in progress.
REQ-017 SHALL have port oOverrun, output, 1: one-cycle pulse when a scan trigger arrives while busy.

Function
REQ-018 Object RAM SHALL be a 16x13 register file; a write is visible to reads from the next cycle, and a same-cycle read returns the old value.
REQ-019 Scan trigger SHALL be iLineStart=1 with iVCnt<480 and iVCnt[4:0]=0; the target row is iVCnt>>5 (0..14), latched at trigger.
REQ-020 FSM states SHALL be IDLE, CLEAR, SCAN; IDLE->CLEAR on trigger; CLEAR runs 19 cycles, invalidating buffer columns 0..18 in order; SCAN runs NUM_OBJ cycles reading entry 0..15, one per cycle; then back to IDLE (35 cycles total).
REQ-021 In SCAN, an entry SHALL be accepted only if ON=1, Y equals the target row, and X<=18; an accepted entry writes {valid=1, tile} into buffer column X only if that column is not already valid, so the lowest address wins.
REQ-022 oScan_busy SHALL be 1 in CLEAR and SCAN; a trigger while busy SHALL be ignored and SHALL pulse oOverrun for one cycle.
REQ-023 Lookup stage 1 SHALL register in_range = (X_OFFSET<=iHCnt<X_OFFSET+608) AND (iVCnt<480), col=(iHCnt-X_OFFSET)>>5, px=(iHCnt-X_OFFSET)[4:0], py=iVCnt[4:0].
REQ-024 Lookup stage 2 SHALL register oTile_valid = in_range AND buffer[col].valid, plus oTile_no, oTile_px, oTile_py; total latency 2 cycles from iHCnt/iVCnt.
REQ-025 When oTile_valid=0, oTile_no SHALL be 0; oTile_px and oTile_py always carry the stage-1 values.
REQ-026 Lookup SHALL read the buffer combinationally during CLEAR/SCAN; correctness is guaranteed only because the scan completes within blanking (35 cycles, fewer than 160).

Reset
REQ-027 Reset SHALL set all RAM entries to 0 (OFF), all buffer columns invalid, FSM to IDLE, the latched row to 0, and all outputs and pipeline registers to 0.
REQ-028 Reset asserted mid-scan SHALL abort the scan immediately; no partial buffer contents remain.

Structure
REQ-029 A shared package SHALL hold NUM_COLS=19, NUM_ROWS=15, object field bit positions, FSM state encoding, and the active-area limits 480/608.
REQ-030 The object RAM SHALL be a sub-module obj_ram (16x13, one write port, one combinational read port).

Verification
REQ-031 Write addr0=0x1000|(3<<4)|2, trigger at iVCnt=64 -> row 2; at iHCnt=16+96..16+127 on line 64, oTile_valid=1, oTile_no=0, px=0..31, 2-cycle lag.
REQ-032 Addr0 and addr1 both at cell (5,1) with tiles 0 and 1 -> oTile_no=0 (lowest address wins).
REQ-033 Entry OFF or X=19 -> oTile_valid=0 across the whole row.
REQ-034 Second iLineStart 10 cycles after a trigger -> oOverrun=1 for 1 cycle; the scan finishes unchanged at cycle 35.
REQ-035 Reset asserted at SCAN cycle 5 -> oScan_busy=0 and all outputs 0 next cycle; a fresh trigger gives oTile_valid=0 everywhere.
REQ-036 iHCnt=15 or 624, or iVCnt=480 -> oTile_valid=0.
